// File: rtl/alu_fwd_pkg.sv
// Shared types for the EX-stage operand forwarding and load-use hazard block.
package alu_fwd_pkg;

  // ALU operand modes as encoded by the decoder
  typedef enum logic [1:0] {
    MODE_R   = 2'b00,
    MODE_I   = 2'b01,
    MODE_VSH = 2'b10,
    MODE_SH  = 2'b11
  } ex_mode_e;

  // Where a channel's forwarded value came from
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Status bits of the destination trackers; register numbers and data are
  // kept beside them at the parameterised widths of the instantiating block.
  typedef struct packed {
    logic v;
    logic we;
    logic ld;
  } trk_mem_t;

  typedef struct packed {
    logic v;
    logic we;
  } trk_wb_t;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } state_e;

  // Which of channels {1,0} an operand mode actually reads
  function automatic logic [1:0] chan_use(input ex_mode_e mode);
    logic [1:0] use_mask;
    case (mode)
      MODE_R:   use_mask = 2'b11;
      MODE_I:   use_mask = 2'b01;
      MODE_SH:  use_mask = 2'b10;
      MODE_VSH: use_mask = 2'b11;
      default:  use_mask = 2'b11;
    endcase
    return use_mask;
  endfunction

endpackage

// File: rtl/alu_operand_fwd_chan.sv
// Per-channel forwarding selector: newest producer wins, and a load still in
// MEM is reported as a hazard instead of being forwarded.
module fwd_chan_sel
  import alu_fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_num,
  input  logic [XLEN-1:0] src_data,
  input  trk_mem_t        mem_trk,
  input  logic [RA_W-1:0] mem_dst,
  input  logic [XLEN-1:0] mem_data,
  input  trk_wb_t         wb_trk,
  input  logic [RA_W-1:0] wb_dst,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value,
  output fwd_sel_e        sel,
  output logic            hazard
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_trk.v & mem_trk.we & (mem_dst == src_num);
  assign wb_hit  = wb_trk.v & wb_trk.we & (wb_dst == src_num);

  // Priority select; register zero always reads the regfile value
  always_comb begin
    value  = src_data;
    sel    = FWD_RF;
    hazard = 1'b0;
    if (src_num != '0) begin
      if (mem_hit && !mem_trk.ld) begin
        value = mem_data;
        sel   = FWD_MEM;
      end else if (mem_hit && mem_trk.ld) begin
        hazard = 1'b1;
      end else if (wb_hit) begin
        value = wb_data;
        sel   = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/alu_operand_fwd.sv
// EX-stage operand forwarding with internal MEM/WB trackers, one-cycle
// load-use stall FSM, saturating stall counter and ALU operand selection.
module alu_operand_fwd
  import alu_fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [NSRC*RA_W-1:0] ex_src_num,
  input  logic [NSRC*XLEN-1:0] ex_src_data,
  input  logic [XLEN-1:0]      ex_imm,
  input  logic [4:0]           ex_shamt,
  input  logic [1:0]           ex_mode,
  input  logic [RA_W-1:0]      ex_dst_num,
  input  logic                 ex_dst_we,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_alu_result,
  input  logic [XLEN-1:0]      wb_write_data,
  input  logic                 hold,
  input  logic                 flush,
  output logic [XLEN-1:0]      op_a,
  output logic [XLEN-1:0]      op_b,
  output logic [NSRC*XLEN-1:0] fwd_data,
  output logic                 lu_stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  trk_mem_t        mem_q, mem_d;
  logic [RA_W-1:0] mem_dst_q, mem_dst_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  trk_wb_t         wb_q, wb_d;
  logic [RA_W-1:0] wb_dst_q, wb_dst_d;
  state_e          state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ex_mode_e        mode;
  logic [1:0]      use_mask;
  logic [NSRC-1:0] chan_haz;
  logic [NSRC-1:0] chan_used;
  logic            hazard;
  logic [XLEN-1:0] fwd0;
  logic [XLEN-1:0] fwd1;
  // Per-channel source select, kept for waveform debug of forwarding paths
  fwd_sel_e        chan_sel_unused [NSRC];

  assign mode     = ex_mode_e'(ex_mode);
  assign use_mask = chan_use(mode);

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_chan
      fwd_chan_sel #(
        .XLEN(XLEN),
        .RA_W(RA_W)
      ) u_sel (
        .src_num (ex_src_num[gi*RA_W +: RA_W]),
        .src_data(ex_src_data[gi*XLEN +: XLEN]),
        .mem_trk (mem_q),
        .mem_dst (mem_dst_q),
        .mem_data(mem_data_q),
        .wb_trk  (wb_q),
        .wb_dst  (wb_dst_q),
        .wb_data (wb_write_data),
        .value   (fwd_data[gi*XLEN +: XLEN]),
        .sel     (chan_sel_unused[gi]),
        .hazard  (chan_haz[gi])
      );
      // Only rs/rt feed the ALU; extra channels forward but never stall
      if (gi < 2) begin : g_used
        assign chan_used[gi] = use_mask[gi];
      end else begin : g_fwd_only
        assign chan_used[gi] = 1'b0;
      end
    end
  endgenerate

  assign hazard = ex_valid & |(chan_haz & chan_used);
  assign fwd0   = fwd_data[0 +: XLEN];
  assign fwd1   = fwd_data[XLEN +: XLEN];

  // Stall FSM: a single bubble per load-use; nothing moves while held
  always_comb begin
    state_d  = state_q;
    lu_stall = 1'b0;
    case (state_q)
      RUN: begin
        lu_stall = hazard & ~flush;
        if (hazard && !hold && !flush) state_d = LU;
      end
      LU: begin
        if (!hold) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Tracker advance: MEM takes EX or a bubble, WB takes MEM
  always_comb begin
    mem_d      = mem_q;
    mem_dst_d  = mem_dst_q;
    mem_data_d = mem_data_q;
    wb_d       = wb_q;
    wb_dst_d   = wb_dst_q;
    if (!hold) begin
      wb_d.v   = mem_q.v;
      wb_d.we  = mem_q.we;
      wb_dst_d = mem_dst_q;
      if (ex_valid && !flush && !lu_stall) begin
        mem_d.v    = 1'b1;
        mem_d.we   = ex_dst_we;
        mem_d.ld   = ex_is_load;
        mem_dst_d  = ex_dst_num;
        mem_data_d = ex_alu_result;
      end else begin
        mem_d = '0;
      end
    end
  end

  // Saturating count of stall cycles that actually cost a bubble
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lu_stall && !hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State, trackers and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      mem_dst_q   <= '0;
      mem_data_q  <= '0;
      wb_q        <= '0;
      wb_dst_q    <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      mem_dst_q   <= mem_dst_d;
      mem_data_q  <= mem_data_d;
      wb_q        <= wb_d;
      wb_dst_q    <= wb_dst_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // ALU operand selection by mode; an empty EX slot drives zeros
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (ex_valid) begin
      case (mode)
        MODE_R: begin
          op_a = fwd0;
          op_b = fwd1;
        end
        MODE_I: begin
          op_a = fwd0;
          op_b = ex_imm;
        end
        MODE_SH: begin
          op_a = fwd1;
          op_b = {{(XLEN-5){1'b0}}, ex_shamt};
        end
        MODE_VSH: begin
          op_a = fwd1;
          op_b = {{(XLEN-5){1'b0}}, fwd0[4:0]};
        end
        default: begin
          op_a = '0;
          op_b = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_fwd.sv
// Directed bench for alu_operand_fwd: forwarding, load-use stall, hold,
// flush, operand modes and asynchronous reset.
module tb_alu_operand_fwd;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int NSRC  = 2;
  localparam int CNT_W = 16;

  localparam logic [1:0] M_R   = 2'b00;
  localparam logic [1:0] M_I   = 2'b01;
  localparam logic [1:0] M_VSH = 2'b10;
  localparam logic [1:0] M_SH  = 2'b11;

  logic                 clk;
  logic                 rst_n;
  logic                 ex_valid;
  logic [NSRC*RA_W-1:0] ex_src_num;
  logic [NSRC*XLEN-1:0] ex_src_data;
  logic [XLEN-1:0]      ex_imm;
  logic [4:0]           ex_shamt;
  logic [1:0]           ex_mode;
  logic [RA_W-1:0]      ex_dst_num;
  logic                 ex_dst_we;
  logic                 ex_is_load;
  logic [XLEN-1:0]      ex_alu_result;
  logic [XLEN-1:0]      wb_write_data;
  logic                 hold;
  logic                 flush;
  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      op_b;
  logic [NSRC*XLEN-1:0] fwd_data;
  logic                 lu_stall;
  logic [CNT_W-1:0]     stall_cnt;

  int checks = 0;
  int errors = 0;

  alu_operand_fwd #(
    .XLEN(XLEN), .RA_W(RA_W), .NSRC(NSRC), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_src_num   (ex_src_num),
    .ex_src_data  (ex_src_data),
    .ex_imm       (ex_imm),
    .ex_shamt     (ex_shamt),
    .ex_mode      (ex_mode),
    .ex_dst_num   (ex_dst_num),
    .ex_dst_we    (ex_dst_we),
    .ex_is_load   (ex_is_load),
    .ex_alu_result(ex_alu_result),
    .wb_write_data(wb_write_data),
    .hold         (hold),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .fwd_data     (fwd_data),
    .lu_stall     (lu_stall),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] mode,
                       input logic [4:0] rs, input logic [31:0] rs_d,
                       input logic [4:0] rt, input logic [31:0] rt_d,
                       input logic [4:0] dst, input logic we, input logic ld,
                       input logic [31:0] alu);
    ex_valid      = v;
    ex_mode       = mode;
    ex_src_num    = {rt, rs};
    ex_src_data   = {rt_d, rs_d};
    ex_dst_num    = dst;
    ex_dst_we     = we;
    ex_is_load    = ld;
    ex_alu_result = alu;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    ex_imm = '0;
    ex_shamt = '0;
    wb_write_data = '0;
    drive(0, M_R, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: operands are regfile data, no stall, counter zero
    drive(1, M_R, 3, 32'h100, 4, 32'h200, 0, 0, 0, 0);
    chk("rst_op_a", op_a, 32'h100);
    chk("rst_op_b", op_b, 32'h200);
    chk("rst_lu", {31'b0, lu_stall}, 32'd0);
    chk("rst_cnt", {16'b0, stall_cnt}, 32'd0);
    tick();

    // Back-to-back: add $3 <- 5+6, then sub using $3
    drive(1, M_R, 1, 5, 2, 6, 3, 1, 0, 11);
    chk("add_op_a", op_a, 32'd5);
    tick();
    drive(1, M_R, 3, 32'h999, 1, 1, 8, 1, 0, 10);
    chk("b2b_op_a", op_a, 32'd11);
    chk("b2b_fwd0", fwd_data[31:0], 32'd11);
    chk("b2b_op_b", op_b, 32'd1);
    chk("b2b_lu", {31'b0, lu_stall}, 32'd0);
    tick();

    // Double forward: $5=9 reaches WB while $4=7 sits in MEM
    drive(1, M_R, 0, 0, 0, 0, 5, 1, 0, 9);
    tick();
    drive(1, M_R, 0, 0, 0, 0, 4, 1, 0, 7);
    tick();
    wb_write_data = 9;
    drive(1, M_R, 4, 32'h44, 5, 32'h55, 2, 1, 0, 1);
    chk("dbl_op_a", op_a, 32'd7);
    chk("dbl_op_b", op_b, 32'd9);
    tick();

    // Newest wins: $2=1 in WB, $2=2 in MEM
    wb_write_data = 0;
    drive(1, M_R, 0, 0, 0, 0, 2, 1, 0, 2);
    tick();
    wb_write_data = 1;
    drive(1, M_R, 2, 32'h22, 0, 0, 0, 1, 0, 32'h77);
    chk("newest_fwd0", fwd_data[31:0], 32'd2);
    chk("newest_op_a", op_a, 32'd2);
    tick();

    // $0 matches the MEM tracker but always reads the regfile; I-mode immediate
    ex_imm = 32'h1234;
    drive(1, M_I, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_op_a", op_a, 32'd0);
    chk("imm_op_b", op_b, 32'h1234);
    tick();

    // Load-use: lw $6 then add $6
    ex_imm = 4;
    drive(1, M_I, 0, 0, 0, 0, 6, 1, 1, 4);
    tick();
    drive(1, M_R, 6, 32'h66, 0, 0, 9, 1, 0, 32'h99);
    chk("lu_stall", {31'b0, lu_stall}, 32'd1);
    chk("lu_cnt0", {16'b0, stall_cnt}, 32'd0);
    tick();
    wb_write_data = 32'hDEAD;
    #1;
    chk("lu_release", {31'b0, lu_stall}, 32'd0);
    chk("lu_cnt1", {16'b0, stall_cnt}, 32'd1);
    chk("lu_op_a", op_a, 32'hDEAD);
    tick();

    // Hold during hazard: stall stays up, counter frozen
    wb_write_data = 0;
    ex_imm = 8;
    drive(1, M_I, 0, 0, 0, 0, 10, 1, 1, 8);
    tick();
    hold = 1'b1;
    drive(1, M_I, 10, 32'hA0, 0, 0, 14, 1, 0, 0);
    chk("hold_lu", {31'b0, lu_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_lu_cyc", {31'b0, lu_stall}, 32'd1);
      chk("hold_cnt_cyc", {16'b0, stall_cnt}, 32'd1);
    end
    hold = 1'b0;
    #1;
    chk("unhold_lu", {31'b0, lu_stall}, 32'd1);
    tick();
    wb_write_data = 32'hBEEF;
    #1;
    chk("unhold_cnt", {16'b0, stall_cnt}, 32'd2);
    chk("unhold_lu_off", {31'b0, lu_stall}, 32'd0);
    chk("unhold_op_a", op_a, 32'hBEEF);
    chk("unhold_op_b", op_b, 32'd8);
    tick();

    // Flush during hazard: no stall, a bubble enters MEM
    wb_write_data = 0;
    drive(1, M_I, 0, 0, 0, 0, 11, 1, 1, 0);
    tick();
    flush = 1'b1;
    drive(1, M_R, 0, 0, 11, 32'hB0, 11, 1, 0, 32'h5555);
    chk("flush_lu", {31'b0, lu_stall}, 32'd0);
    tick();
    flush = 1'b0;
    wb_write_data = 32'hCAFE;
    drive(1, M_R, 0, 0, 11, 32'hB0, 0, 0, 0, 0);
    chk("flush_op_b", op_b, 32'hCAFE);
    chk("flush_cnt", {16'b0, stall_cnt}, 32'd2);
    tick();

    // Channel use per mode against a load in MEM
    wb_write_data = 0;
    drive(1, M_I, 0, 0, 0, 0, 15, 1, 1, 0);
    tick();
    drive(1, M_I, 0, 0, 15, 32'hF0, 0, 0, 0, 0);
    chk("use_i_rt", {31'b0, lu_stall}, 32'd0);
    drive(1, M_SH, 15, 32'hF0, 0, 0, 0, 0, 0, 0);
    chk("use_sh_rs", {31'b0, lu_stall}, 32'd0);
    drive(1, M_R, 0, 0, 15, 32'hF0, 0, 0, 0, 0);
    chk("use_r_rt", {31'b0, lu_stall}, 32'd1);
    drive(1, M_I, 0, 0, 15, 32'hF0, 0, 0, 0, 0);
    tick();

    // Var-shift with rs=$7=0x23 forwarded from MEM; then fixed shift
    drive(1, M_R, 0, 0, 0, 0, 7, 1, 0, 32'h23);
    tick();
    drive(1, M_VSH, 7, 0, 12, 32'h80, 0, 0, 0, 0);
    chk("vsh_op_a", op_a, 32'h80);
    chk("vsh_op_b", op_b, 32'd3);
    ex_shamt = 5;
    drive(1, M_SH, 7, 0, 12, 32'h80, 0, 0, 0, 0);
    chk("sh_op_a", op_a, 32'h80);
    chk("sh_op_b", op_b, 32'd5);
    drive(0, M_SH, 7, 0, 12, 32'h80, 0, 0, 0, 0);
    chk("inv_op_a", op_a, 32'd0);
    chk("inv_op_b", op_b, 32'd0);
    chk("inv_fwd0", fwd_data[31:0], 32'h23);
    tick();

    // Reset asserted mid-stall
    drive(1, M_I, 0, 0, 0, 0, 13, 1, 1, 0);
    tick();
    drive(1, M_R, 13, 32'hD0, 0, 0, 0, 0, 0, 0);
    chk("rlu_lu", {31'b0, lu_stall}, 32'd1);
    tick();
    chk("rlu_cnt3", {16'b0, stall_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rlu_cnt_rst", {16'b0, stall_cnt}, 32'd0);
    chk("rlu_lu_rst", {31'b0, lu_stall}, 32'd0);
    chk("rlu_op_a_rst", op_a, 32'hD0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_op_a", op_a, 32'hD0);
    chk("post_rst_lu", {31'b0, lu_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
